// File: rtl/codec_frame_serializer.sv
// Codec-side frame generator: captures stereo samples and shifts one pair per frame out as left-justified serial audio.
// Latency: outputs registered, frame-start effects one cycle after trigger; no backpressure (overwrites flag overrun).
module codec_frame_serializer #(
   parameter int BCLK_DIV = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] sample_left,
   input  logic [15:0] sample_right,
   input  logic        new_sample_generated,
   output logic        new_frame,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        underrun,
   output logic        overrun
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [5:0]  bit_q, bit_d;
   logic [63:0] shift_q, shift_d;
   logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic        hold_vld_q, hold_vld_d;
   logic [15:0] last_l_q, last_l_d, last_r_q, last_r_d;
   logic        bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
   logic        new_frame_q, new_frame_d, underrun_q, underrun_d, overrun_q, overrun_d;
   logic        frame_start;
   logic [5:0]  next_bit;
   logic [15:0] pair_l, pair_r;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      hold_vld_d  = hold_vld_q;
      last_l_d    = last_l_q;
      last_r_d    = last_r_q;
      bclk_d      = bclk_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      new_frame_d = 1'b0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      frame_start = 1'b0;
      next_bit    = bit_q + 6'd1;
      pair_l      = hold_vld_q ? hold_l_q : last_l_q;
      pair_r      = hold_vld_q ? hold_r_q : last_r_q;

      case (state_q)
         IDLE: begin
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            if (enable) begin
               frame_start = 1'b1;
               state_d     = RUN;
            end
         end
         default: begin
            if (!enable) begin
               state_d = IDLE;
               bclk_d  = 1'b0;
               lrclk_d = 1'b0;
               sdata_d = 1'b0;
               div_d   = '0;
               bit_d   = '0;
            end else if (div_q == DIV_TC) begin
               div_d  = '0;
               bclk_d = ~bclk_q;
               // Data only moves on the falling bclk edge so the receiver sees it stable at the rise.
               if (bclk_q) begin
                  if (bit_q == 6'd63) begin
                     frame_start = 1'b1;
                  end else begin
                     bit_d   = next_bit;
                     shift_d = {shift_q[62:0], 1'b0};
                     sdata_d = shift_q[62];
                     lrclk_d = next_bit[5];
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
      endcase

      if (frame_start) begin
         shift_d     = {pair_l, 16'h0000, pair_r, 16'h0000};
         last_l_d    = pair_l;
         last_r_d    = pair_r;
         hold_vld_d  = 1'b0;
         underrun_d  = ~hold_vld_q;
         new_frame_d = 1'b1;
         lrclk_d     = 1'b0;
         sdata_d     = pair_l[15];
         bit_d       = '0;
         div_d       = '0;
         bclk_d      = 1'b0;
      end

      // Capture after the frame load so a coincident strobe feeds the next frame.
      if (new_sample_generated) begin
         hold_l_d   = sample_left;
         hold_r_d   = sample_right;
         hold_vld_d = 1'b1;
         overrun_d  = hold_vld_q & ~frame_start;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         hold_vld_q  <= 1'b0;
         last_l_q    <= '0;
         last_r_q    <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         new_frame_q <= 1'b0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         hold_vld_q  <= hold_vld_d;
         last_l_q    <= last_l_d;
         last_r_q    <= last_r_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         new_frame_q <= new_frame_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
      end
   end

   assign new_frame = new_frame_q;
   assign bclk      = bclk_q;
   assign lrclk     = lrclk_q;
   assign sdata     = sdata_q;
   assign underrun  = underrun_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_codec_frame_serializer.sv
// Directed bench for codec_frame_serializer with BCLK_DIV=2 (4-cycle bit, 256-cycle frame).
module tb_codec_frame_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] sample_left = '0;
   logic [15:0] sample_right = '0;
   logic        new_sample_generated = 1'b0;
   logic        new_frame, bclk, lrclk, sdata, underrun, overrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] rx_bits, rx_lr, rx_bhi, rx_blo;
   int          rx_ov, rx_nf;

   localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] BHI_EXP = 64'hFFFF_FFFF_FFFF_FFFF;

   codec_frame_serializer #(.BCLK_DIV(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .enable               (enable),
      .sample_left          (sample_left),
      .sample_right         (sample_right),
      .new_sample_generated (new_sample_generated),
      .new_frame            (new_frame),
      .bclk                 (bclk),
      .lrclk                (lrclk),
      .sdata                (sdata),
      .underrun             (underrun),
      .overrun              (overrun)
   );

   always #5 clk = ~clk;

   // Called at the negedge of a new_frame cycle; returns at the negedge 256 cycles later.
   // Strobes at offset s1/s2 (relative cycle) drive the given pairs for one cycle.
   task automatic rx_frame(input int s1, input logic [15:0] l1, input logic [15:0] r1,
                           input int s2, input logic [15:0] l2, input logic [15:0] r2);
      rx_bits = '0; rx_lr = '0; rx_bhi = '0; rx_blo = '0;
      rx_ov = 0; rx_nf = 0;
      for (int c = 1; c <= 256; c++) begin
         @(negedge clk);
         if (c % 4 == 2) begin
            rx_bits[63 - (c / 4)] = sdata;
            rx_lr[63 - (c / 4)]   = lrclk;
            rx_bhi[c / 4]         = bclk;
         end
         if (c % 4 == 0 && c < 256) rx_blo[c / 4] = bclk;
         if (overrun) rx_ov++;
         if (new_frame && c < 256) rx_nf++;
         if (c == s1) begin
            new_sample_generated = 1'b1; sample_left = l1; sample_right = r1;
         end else if (c == s2) begin
            new_sample_generated = 1'b1; sample_left = l2; sample_right = r2;
         end else begin
            new_sample_generated = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if ({new_frame, bclk, lrclk, sdata, underrun, overrun} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, expected 000000",
                  {new_frame, bclk, lrclk, sdata, underrun, overrun});
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({new_frame, bclk, lrclk, sdata} !== 4'b0) begin
         n_fail++;
         $display("FAIL idle_outputs: got %b, expected 0000", {new_frame, bclk, lrclk, sdata});
      end
   endtask

   task automatic test_underrun_idle_link;
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({new_frame, underrun, bclk} !== 3'b110) begin
         n_fail++;
         $display("FAIL first_frame: nf/ur/bclk=%b, expected 110", {new_frame, underrun, bclk});
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h0) begin
         n_fail++; $display("FAIL empty_sdata: got %h, expected 0", rx_bits);
      end
      n_checks++;
      if (rx_bhi !== BHI_EXP || rx_blo !== 64'h0) begin
         n_fail++; $display("FAIL bclk_period: hi=%h lo=%h, expected all-ones/zero", rx_bhi, rx_blo);
      end
      n_checks++;
      if (rx_lr !== LR_EXP) begin
         n_fail++; $display("FAIL lrclk_slots: got %h, expected %h", rx_lr, LR_EXP);
      end
      n_checks++;
      if (rx_nf !== 0 || new_frame !== 1'b1 || underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_period: midframe=%0d nf=%b ur=%b, expected 0 1 1", rx_nf, new_frame, underrun);
      end
   endtask

   task automatic test_single_sample;
      rx_frame(10, 16'hA5C3, 16'h8001, -1, 16'h0, 16'h0);
      n_checks++;
      if (new_frame !== 1'b1 || underrun !== 1'b0) begin
         n_fail++; $display("FAIL sample_no_underrun: nf=%b ur=%b, expected 1 0", new_frame, underrun);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'hA5C3_0000_8001_0000) begin
         n_fail++; $display("FAIL sample_bits: got %h, expected a5c3000080010000", rx_bits);
      end
      n_checks++;
      if (rx_lr !== LR_EXP) begin
         n_fail++; $display("FAIL sample_lrclk: got %h, expected %h", rx_lr, LR_EXP);
      end
      n_checks++;
      if (underrun !== 1'b1) begin
         n_fail++; $display("FAIL repeat_underrun: got %b, expected 1", underrun);
      end
   endtask

   task automatic test_overrun;
      rx_frame(20, 16'h1234, 16'h5678, 100, 16'h9ABC, 16'hDEF0);
      n_checks++;
      if (rx_bits !== 64'hA5C3_0000_8001_0000) begin
         n_fail++; $display("FAIL last_sent_repeat: got %h, expected a5c3000080010000", rx_bits);
      end
      n_checks++;
      if (rx_ov !== 1 || underrun !== 1'b0) begin
         n_fail++; $display("FAIL overrun_count: ov=%0d ur=%b, expected 1 0", rx_ov, underrun);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h9ABC_0000_DEF0_0000 || rx_ov !== 0) begin
         n_fail++; $display("FAIL overrun_winner: got %h ov=%0d, expected 9abc0000def00000 0", rx_bits, rx_ov);
      end
   endtask

   task automatic test_simultaneous;
      rx_frame(255, 16'h1357, 16'h2468, -1, 16'h0, 16'h0);
      n_checks++;
      if (new_frame !== 1'b1 || underrun !== 1'b1 || rx_ov !== 0) begin
         n_fail++;
         $display("FAIL simul_start: nf=%b ur=%b ov=%0d, expected 1 1 0", new_frame, underrun, rx_ov);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h9ABC_0000_DEF0_0000) begin
         n_fail++; $display("FAIL simul_repeat: got %h, expected 9abc0000def00000", rx_bits);
      end
      n_checks++;
      if (underrun !== 1'b0) begin
         n_fail++; $display("FAIL simul_captured: ur=%b, expected 0", underrun);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h1357_0000_2468_0000) begin
         n_fail++; $display("FAIL simul_next: got %h, expected 1357000024680000", rx_bits);
      end
   endtask

   task automatic test_enable_abort;
      int nf_seen;
      int bclk_seen;
      for (int c = 1; c <= 82; c++) begin
         @(negedge clk);
         new_sample_generated = (c == 10);
         if (c == 10) begin
            sample_left = 16'h0F0F; sample_right = 16'hF0F0;
         end
      end
      n_checks++;
      if (bclk !== 1'b1) begin
         n_fail++; $display("FAIL bit20_bclk: got %b, expected 1", bclk);
      end
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bclk, lrclk, sdata} !== 3'b000) begin
         n_fail++; $display("FAIL abort_outputs: got %b, expected 000", {bclk, lrclk, sdata});
      end
      nf_seen = 0; bclk_seen = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (new_frame) nf_seen++;
         if (bclk) bclk_seen++;
      end
      n_checks++;
      if (nf_seen !== 0 || bclk_seen !== 0) begin
         n_fail++; $display("FAIL idle_quiet: nf=%0d bclk=%0d, expected 0 0", nf_seen, bclk_seen);
      end
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (new_frame !== 1'b1 || underrun !== 1'b0) begin
         n_fail++; $display("FAIL reenable: nf=%b ur=%b, expected 1 0", new_frame, underrun);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h0F0F_0000_F0F0_0000) begin
         n_fail++; $display("FAIL retained_pair: got %h, expected 0f0f0000f0f00000", rx_bits);
      end
   endtask

   task automatic test_async_reset;
      for (int c = 1; c <= 162; c++) @(negedge clk);
      n_checks++;
      if ({bclk, lrclk, sdata} !== 3'b111) begin
         n_fail++; $display("FAIL right_slot_pre: got %b, expected 111", {bclk, lrclk, sdata});
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({new_frame, bclk, lrclk, sdata, underrun, overrun} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b, expected 000000",
                  {new_frame, bclk, lrclk, sdata, underrun, overrun});
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (new_frame !== 1'b1 || underrun !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_frame: nf=%b ur=%b, expected 1 1", new_frame, underrun);
      end
      rx_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
      n_checks++;
      if (rx_bits !== 64'h0) begin
         n_fail++; $display("FAIL post_reset_zeros: got %h, expected 0", rx_bits);
      end
   endtask

   initial begin
      test_reset();
      test_underrun_idle_link();
      test_single_sample();
      test_overrun();
      test_simultaneous();
      test_enable_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/codec_frame_serializer.md
# codec_frame_serializer

Codec-side end of the sample interface driven by `music_player`. It generates the one-cycle `new_frame` strobe at the audio frame rate and captures the `sample_left`/`sample_right` pair whenever `new_sample_generated` pulses. Each frame it serializes one stereo pair onto a left-justified bit-clock/word-clock/serial-data link to the DAC. It also flags underrun (no sample arrived in a frame) and overrun (more than one sample arrived in a frame).

## Interface
- `BCLK_DIV`, default 16: clk cycles per bclk half-period; legal values ≥2. Frame length is 128·BCLK_DIV clk cycles.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: run the link. Low holds the block idle.
- `sample_left` in 16: left sample, two's complement.
- `sample_right` in 16: right sample, two's complement.
- `new_sample_generated` in 1: one-cycle strobe; capture both samples this cycle.
- `new_frame` out 1: one-cycle strobe at each frame start.
- `bclk` out 1: serial bit clock.
- `lrclk` out 1: word select; 0 = left slot, 1 = right slot.
- `sdata` out 1: serial data, MSB first.
- `underrun` out 1: one-cycle pulse, coincident with `new_frame`.
- `overrun` out 1: one-cycle pulse.

## Operation
- **Reset values:** all outputs 0; holding register 0, its valid flag 0; last-sent pair 0; counters 0; state IDLE.
- **States:**
  - IDLE: `bclk`, `lrclk` and `sdata` are held at 0.
  - IDLE→RUN on the first cycle with `enable`=1; that cycle is a frame-start event.
  - RUN→IDLE on any cycle with `enable`=0. The frame is aborted, outputs return to 0 on the next edge, and the holding register and valid flag are retained.
- **Frame format:** 64 bits.
  - Bits 0–31 are the left slot, bits 32–63 the right slot.
  - Each slot carries the 16 sample bits MSB first, then 16 zeros.
  - `lrclk` = 1 exactly while bit index ≥32.
- **Capture:** on `new_sample_generated`, both inputs are written to the holding register and valid is set. If valid was already 1 and this is not a frame-start cycle, the new pair overwrites the old one and `overrun` pulses on the next edge.
- **Frame-start event** (IDLE→RUN entry, or bit index wrapping 63→0):
  - If valid: holding pair → 64-bit shift register and last-sent register; valid is cleared.
  - If not valid: last-sent pair is reloaded and `underrun`=1.
  - `new_frame`=1, `lrclk`=0, `sdata`=left[15], bit index=0.
- **Simultaneous frame start and `new_sample_generated`:**
  - The frame loads the pre-existing holding content (or last-sent on underrun).
  - The incoming pair is captured afterwards and valid ends at 1.
  - No overrun is flagged.
- **Clock generation:**
  - A divider counts 0..BCLK_DIV−1; on terminal count it wraps to 0 and `bclk` toggles.
  - On a toggle from 1→0 (falling edge), the bit index advances: `sdata` presents the next bit and `lrclk` updates.
  - The receiver samples on the rising edge.
- **Arithmetic:**
  - Bit index is 6 bits and wraps modulo 64.
  - Divider width is $clog2(BCLK_DIV).
  - No sign extension or scaling is applied; samples are passed bit-exact.

## Timing
- All outputs are registered. Frame-start outputs appear on the edge after the triggering cycle.
- `new_frame`, `underrun` and `overrun` are high for exactly one cycle.
- **After enable rises at cycle E:**
  - `new_frame` is high in cycle E+1.
  - First `bclk` rise at E+1+BCLK_DIV.
  - Each bit lasts 2·BCLK_DIV cycles.
  - The next `new_frame` is at E+1+128·BCLK_DIV, then every 128·BCLK_DIV cycles.
- **Capture latency:** one cycle (the strobe cycle's inputs are registered). A sample captured any time up to and including the frame-start cycle counts for the following frame.
- **Asynchronous reset mid-frame:** all outputs go to 0 immediately. Leaving reset with `enable`=1 starts a fresh frame on the first clock edge, with underrun=1 because valid=0.

## Test plan
- Reset, `enable`=1, BCLK_DIV=2, no samples supplied → `new_frame` every 256 cycles, `underrun` with each one, `sdata` stays 0, `bclk` period 4 cycles.
- Strobe L=16'hA5C3, R=16'h8001 shortly after a `new_frame` → next frame shifts out 1010010111000011 then 16 zeros with `lrclk`=0, then 1000000000000001 and 16 zeros with `lrclk`=1; `underrun`=0.
- Two strobes (1234/5678, then 9ABC/DEF0) within one frame → one `overrun` pulse; 9ABC/DEF0 is transmitted.
- Strobe in the same cycle as a frame start, holding empty → that frame repeats the last-sent pair with `underrun`=1; the following frame sends the new pair with no underrun.
- Deassert `enable` at bit 20 → `bclk`/`lrclk`/`sdata` are 0 one cycle later and no further `new_frame`; re-enable → `new_frame` on the next cycle, holding pair retained.
- Assert `reset` mid right slot → all outputs 0 asynchronously; after release, `new_frame` and `underrun` pulse together and the frame transmits zeros.
